// File: rtl/hit_judge_pkg.sv
// Shared game definitions: sprite geometry, game and judge state encodings,
// the 12-bit signed coordinate/box types and coordinate widening helpers.
package hit_judge_pkg;

  // Sprite geometry, shared by every module that reasons about boxes
  localparam int MARIO_W_DEF   = 34;
  localparam int MARIO_H_DEF   = 36;
  localparam int BARREL_HW_DEF = 20;
  localparam int BARREL_HH_DEF = 30;
  localparam int QUEUE_HW_DEF  = 22;
  localparam int QUEUE_HH_DEF  = 25;

  // Box arithmetic width: wide enough that centre - half-size never wraps
  localparam int COORD_W = 12;

  typedef logic signed [COORD_W-1:0] coord_t;

  // Top-level game FSM encodings
  typedef enum logic [1:0] {
    GAME_IDLE    = 2'd0,
    GAME_RUNNING = 2'd1,
    GAME_OVER    = 2'd2,
    GAME_SUCCESS = 2'd3
  } game_state_e;

  // Hit-judge FSM encodings (also shown on the seg7 debug display)
  typedef enum logic [2:0] {
    JUDGE_IDLE  = 3'd0,
    JUDGE_GRACE = 3'd1,
    JUDGE_ARMED = 3'd2,
    JUDGE_LOST  = 3'd3,
    JUDGE_WON   = 3'd4
  } judge_state_e;

  // Half-open box [x_lo, x_hi) by [y_lo, y_hi)
  typedef struct packed {
    coord_t x_lo;
    coord_t x_hi;
    coord_t y_lo;
    coord_t y_hi;
  } box_t;

  // Zero-extend a 10-bit screen x into the signed box domain
  function automatic coord_t widen_x(input logic [9:0] v);
    return coord_t'({2'b00, v});
  endfunction

  // Zero-extend a 9-bit screen y into the signed box domain
  function automatic coord_t widen_y(input logic [8:0] v);
    return coord_t'({3'b000, v});
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Bus between the game core and the hit judge: tick/control strobes,
// sprite positions in, judged result and debug levels out.
interface hit_judge_if;
  logic       tick;
  logic       enable;
  logic       clear;
  logic [9:0] mario_x;
  logic [8:0] mario_y;
  logic [9:0] barrel_x;
  logic [8:0] barrel_y;
  logic       barrel_valid;
  logic [9:0] queue_x;
  logic [8:0] queue_y;
  logic       over;
  logic       success;
  logic [2:0] judge_state;
  logic       barrel_ovl;
  logic       queue_ovl;

  modport master (
    output tick, enable, clear,
    output mario_x, mario_y, barrel_x, barrel_y, barrel_valid, queue_x, queue_y,
    input  over, success, judge_state, barrel_ovl, queue_ovl
  );

  modport slave (
    input  tick, enable, clear,
    input  mario_x, mario_y, barrel_x, barrel_y, barrel_valid, queue_x, queue_y,
    output over, success, judge_state, barrel_ovl, queue_ovl
  );
endinterface

// File: rtl/hit_judge_box_overlap.sv
// Combinational strict overlap test of two half-open boxes; touching edges
// do not count as overlap.
module box_overlap
  import hit_judge_pkg::*;
(
  input  box_t a_i,
  input  box_t b_i,
  output logic ovl_o
);

  coord_t a_xl, a_xh, a_yl, a_yh;
  coord_t b_xl, b_xh, b_yl, b_yh;

  assign a_xl = a_i.x_lo;
  assign a_xh = a_i.x_hi;
  assign a_yl = a_i.y_lo;
  assign a_yh = a_i.y_hi;
  assign b_xl = b_i.x_lo;
  assign b_xh = b_i.x_hi;
  assign b_yl = b_i.y_lo;
  assign b_yh = b_i.y_hi;

  // Both axes must overlap strictly, compared as signed values
  always_comb begin
    ovl_o = (a_xl < b_xh) && (b_xl < a_xh) && (a_yl < b_yh) && (b_yl < a_yh);
  end

endmodule

// File: rtl/hit_judge.sv
// Game-rule judge: on each game tick tests Mario against the barrel and the
// queue, confirms a hit or a win after enough consecutive overlapping ticks
// and latches the result until clear or reset.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int MARIO_W     = MARIO_W_DEF,
  parameter int MARIO_H     = MARIO_H_DEF,
  parameter int BARREL_HW   = BARREL_HW_DEF,
  parameter int BARREL_HH   = BARREL_HH_DEF,
  parameter int QUEUE_HW    = QUEUE_HW_DEF,
  parameter int QUEUE_HH    = QUEUE_HH_DEF,
  parameter int SHRINK      = 4,
  parameter int HIT_TICKS   = 2,
  parameter int WIN_TICKS   = 3,
  parameter int GRACE_TICKS = 16
) (
  input  logic         clk,
  input  logic         rst,
  hit_judge_if.slave   bus
);

  localparam int HIT_W   = $clog2(HIT_TICKS + 1);
  localparam int WIN_W   = $clog2(WIN_TICKS + 1);
  localparam int GRACE_W = $clog2(GRACE_TICKS + 1);

  localparam logic [HIT_W-1:0]   HIT_MAX   = HIT_W'(HIT_TICKS);
  localparam logic [WIN_W-1:0]   WIN_MAX   = WIN_W'(WIN_TICKS);
  localparam logic [GRACE_W-1:0] GRACE_MAX = GRACE_W'(GRACE_TICKS);

  localparam coord_t C_MARIO_W   = coord_t'(MARIO_W);
  localparam coord_t C_MARIO_H   = coord_t'(MARIO_H);
  localparam coord_t C_BARREL_HW = coord_t'(BARREL_HW);
  localparam coord_t C_BARREL_HH = coord_t'(BARREL_HH);
  localparam coord_t C_QUEUE_HW  = coord_t'(QUEUE_HW);
  localparam coord_t C_QUEUE_HH  = coord_t'(QUEUE_HH);
  localparam coord_t C_SHRINK    = coord_t'(SHRINK);

  coord_t mx, my, bx, by, qx, qy;
  box_t   mario_shrunk, mario_full, barrel_box, queue_box;
  logic   barrel_geom, queue_geom;
  logic   barrel_hit, queue_hit;
  logic   flush;

  judge_state_e        state_q, state_d;
  logic [HIT_W-1:0]    hit_cnt_q, hit_cnt_d, hit_inc;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d, win_inc;
  logic [GRACE_W-1:0]  grace_cnt_q, grace_cnt_d;
  logic                barrel_ovl_q, barrel_ovl_d;
  logic                queue_ovl_q, queue_ovl_d;

  assign mx = widen_x(bus.mario_x);
  assign my = widen_y(bus.mario_y);
  assign bx = widen_x(bus.barrel_x);
  assign by = widen_y(bus.barrel_y);
  assign qx = widen_x(bus.queue_x);
  assign qy = widen_y(bus.queue_y);

  // Build the four boxes; the barrel test uses a trimmed Mario to be forgiving
  always_comb begin
    mario_shrunk.x_lo = mx + C_SHRINK;
    mario_shrunk.x_hi = mx + C_MARIO_W - C_SHRINK;
    mario_shrunk.y_lo = my + C_SHRINK;
    mario_shrunk.y_hi = my + C_MARIO_H - C_SHRINK;
    mario_full.x_lo   = mx;
    mario_full.x_hi   = mx + C_MARIO_W;
    mario_full.y_lo   = my;
    mario_full.y_hi   = my + C_MARIO_H;
    barrel_box.x_lo   = bx - C_BARREL_HW;
    barrel_box.x_hi   = bx + C_BARREL_HW;
    barrel_box.y_lo   = by - C_BARREL_HH;
    barrel_box.y_hi   = by + C_BARREL_HH;
    queue_box.x_lo    = qx - C_QUEUE_HW;
    queue_box.x_hi    = qx + C_QUEUE_HW;
    queue_box.y_lo    = qy - C_QUEUE_HH;
    queue_box.y_hi    = qy + C_QUEUE_HH;
  end

  box_overlap u_barrel_ovl (
    .a_i   (mario_shrunk),
    .b_i   (barrel_box),
    .ovl_o (barrel_geom)
  );

  box_overlap u_queue_ovl (
    .a_i   (mario_full),
    .b_i   (queue_box),
    .ovl_o (queue_geom)
  );

  assign barrel_hit = barrel_geom & bus.barrel_valid;
  assign queue_hit  = queue_geom;

  // Saturating increments so a held overlap can never wrap the counters
  assign hit_inc = (hit_cnt_q == HIT_MAX) ? hit_cnt_q : hit_cnt_q + 1'b1;
  assign win_inc = (win_cnt_q == WIN_MAX) ? win_cnt_q : win_cnt_q + 1'b1;

  // Leaving an active round (clear anywhere, or disable before a result) resets everything
  assign flush = bus.clear |
                 (~bus.enable & ((state_q == JUDGE_GRACE) | (state_q == JUDGE_ARMED)));

  // State, counters and sampled overlaps
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= JUDGE_IDLE;
      hit_cnt_q    <= '0;
      win_cnt_q    <= '0;
      grace_cnt_q  <= '0;
      barrel_ovl_q <= 1'b0;
      queue_ovl_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_cnt_q    <= hit_cnt_d;
      win_cnt_q    <= win_cnt_d;
      grace_cnt_q  <= grace_cnt_d;
      barrel_ovl_q <= barrel_ovl_d;
      queue_ovl_q  <= queue_ovl_d;
    end
  end

  // Next-state logic: clear beats tick, LOST beats WON on a simultaneous confirm
  always_comb begin
    state_d      = state_q;
    hit_cnt_d    = hit_cnt_q;
    win_cnt_d    = win_cnt_q;
    grace_cnt_d  = grace_cnt_q;
    barrel_ovl_d = barrel_ovl_q;
    queue_ovl_d  = queue_ovl_q;

    if (flush) begin
      state_d      = JUDGE_IDLE;
      hit_cnt_d    = '0;
      win_cnt_d    = '0;
      grace_cnt_d  = '0;
      barrel_ovl_d = 1'b0;
      queue_ovl_d  = 1'b0;
    end else begin
      if (bus.tick) begin
        barrel_ovl_d = barrel_hit;
        queue_ovl_d  = queue_hit;
      end
      unique case (state_q)
        JUDGE_IDLE: begin
          hit_cnt_d = '0;
          win_cnt_d = '0;
          if (bus.enable) begin
            state_d     = JUDGE_GRACE;
            grace_cnt_d = GRACE_MAX;
          end
        end
        JUDGE_GRACE: begin
          if (bus.tick) begin
            if (grace_cnt_q <= GRACE_W'(1)) begin
              grace_cnt_d = '0;
              state_d     = JUDGE_ARMED;
            end else begin
              grace_cnt_d = grace_cnt_q - 1'b1;
            end
          end
        end
        JUDGE_ARMED: begin
          if (bus.tick) begin
            hit_cnt_d = barrel_hit ? hit_inc : '0;
            win_cnt_d = queue_hit  ? win_inc : '0;
            if (hit_cnt_d == HIT_MAX) begin
              state_d = JUDGE_LOST;
            end else if (win_cnt_d == WIN_MAX) begin
              state_d = JUDGE_WON;
            end
          end
        end
        JUDGE_LOST, JUDGE_WON: begin
          state_d = state_q;
        end
        default: begin
          state_d = JUDGE_IDLE;
        end
      endcase
    end
  end

  assign bus.over        = (state_q == JUDGE_LOST);
  assign bus.success     = (state_q == JUDGE_WON);
  assign bus.judge_state = state_q;
  assign bus.barrel_ovl  = barrel_ovl_q;
  assign bus.queue_ovl   = queue_ovl_q;

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: two instances (default thresholds, and WIN_TICKS=2)
// driven by the same stimulus and compared every cycle against a rule-level
// model of the game judge, followed by directed scenarios and random play.
module tb_hit_judge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hit_judge_if jif0 ();
  hit_judge_if jif1 ();

  logic       s_tick, s_enable, s_clear, s_valid;
  logic [9:0] s_mx, s_bx, s_qx;
  logic [8:0] s_my, s_by, s_qy;

  assign jif0.tick = s_tick;         assign jif1.tick = s_tick;
  assign jif0.enable = s_enable;     assign jif1.enable = s_enable;
  assign jif0.clear = s_clear;       assign jif1.clear = s_clear;
  assign jif0.mario_x = s_mx;        assign jif1.mario_x = s_mx;
  assign jif0.mario_y = s_my;        assign jif1.mario_y = s_my;
  assign jif0.barrel_x = s_bx;       assign jif1.barrel_x = s_bx;
  assign jif0.barrel_y = s_by;       assign jif1.barrel_y = s_by;
  assign jif0.barrel_valid = s_valid; assign jif1.barrel_valid = s_valid;
  assign jif0.queue_x = s_qx;        assign jif1.queue_x = s_qx;
  assign jif0.queue_y = s_qy;        assign jif1.queue_y = s_qy;

  hit_judge dut0 (.clk(clk), .rst(rst), .bus(jif0.slave));
  hit_judge #(.WIN_TICKS(2)) dut1 (.clk(clk), .rst(rst), .bus(jif1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game rules at the level of "what has happened so far"
  int m_state[2], m_hit[2], m_win[2], m_grace[2];
  bit m_bo[2], m_qo[2];
  int hit_thr[2] = '{2, 2};
  int win_thr[2] = '{3, 2};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit span(input int alo, input int ahi, input int blo, input int bhi);
    return (alo < bhi) && (blo < ahi);
  endfunction

  task automatic model_step();
    int mx, my, bx, by, qx, qy;
    bit bov, qov;
    mx = int'(s_mx); my = int'(s_my); bx = int'(s_bx);
    by = int'(s_by); qx = int'(s_qx); qy = int'(s_qy);
    bov = s_valid && span(mx + 4, mx + 34 - 4, bx - 20, bx + 20)
                  && span(my + 4, my + 36 - 4, by - 30, by + 30);
    qov = span(mx, mx + 34, qx - 22, qx + 22) && span(my, my + 36, qy - 25, qy + 25);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] = 0; m_hit[k] = 0; m_win[k] = 0; m_grace[k] = 0;
        m_bo[k] = 0; m_qo[k] = 0;
      end else if (s_clear || (!s_enable && (m_state[k] == 1 || m_state[k] == 2))) begin
        m_state[k] = 0; m_hit[k] = 0; m_win[k] = 0; m_grace[k] = 0;
        m_bo[k] = 0; m_qo[k] = 0;
      end else begin
        if (s_tick) begin
          m_bo[k] = bov;
          m_qo[k] = qov;
        end
        if (m_state[k] == 0) begin
          if (s_enable) begin
            m_state[k] = 1; m_grace[k] = 16; m_hit[k] = 0; m_win[k] = 0;
          end
        end else if (m_state[k] == 1) begin
          if (s_tick) begin
            m_grace[k]--;
            if (m_grace[k] == 0) m_state[k] = 2;
          end
        end else if (m_state[k] == 2) begin
          if (s_tick) begin
            m_hit[k] = bov ? ((m_hit[k] + 1 > hit_thr[k]) ? hit_thr[k] : m_hit[k] + 1) : 0;
            m_win[k] = qov ? ((m_win[k] + 1 > win_thr[k]) ? win_thr[k] : m_win[k] + 1) : 0;
            if (m_hit[k] == hit_thr[k]) m_state[k] = 3;
            else if (m_win[k] == win_thr[k]) m_state[k] = 4;
          end
        end
      end
    end
  endtask

  task automatic check_dut(input int k);
    string p;
    p = (k == 0) ? "u0" : "u1";
    if (k == 0) begin
      check({p, ".state"},   32'(jif0.judge_state), 32'(m_state[0]));
      check({p, ".over"},    32'(jif0.over),        32'(m_state[0] == 3));
      check({p, ".success"}, 32'(jif0.success),     32'(m_state[0] == 4));
      check({p, ".bovl"},    32'(jif0.barrel_ovl),  32'(m_bo[0]));
      check({p, ".qovl"},    32'(jif0.queue_ovl),   32'(m_qo[0]));
    end else begin
      check({p, ".state"},   32'(jif1.judge_state), 32'(m_state[1]));
      check({p, ".over"},    32'(jif1.over),        32'(m_state[1] == 3));
      check({p, ".success"}, 32'(jif1.success),     32'(m_state[1] == 4));
      check({p, ".bovl"},    32'(jif1.barrel_ovl),  32'(m_bo[1]));
      check({p, ".qovl"},    32'(jif1.queue_ovl),   32'(m_qo[1]));
    end
  endtask

  // One clock: model the edge, let the DUT take it, compare just after
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      s_tick = 1'b1; cyc();
      s_tick = 1'b0; cyc();
    end
  endtask

  task automatic set_pos(input int mx, input int my, input int bx, input int by,
                         input bit bv, input int qx, input int qy);
    s_mx = 10'(mx); s_my = 9'(my); s_bx = 10'(bx); s_by = 9'(by);
    s_valid = bv; s_qx = 10'(qx); s_qy = 9'(qy);
  endtask

  task automatic far_pos();
    set_pos(100, 200, 600, 400, 1'b0, 900, 450);
  endtask

  // Return to IDLE, re-enter GRACE and run out the grace period with nothing nearby
  task automatic arm();
    far_pos();
    s_enable = 1'b1;
    s_clear = 1'b1; cyc();
    s_clear = 1'b0; cyc();
    ticks(16);
  endtask

  initial begin
    s_tick = 0; s_enable = 0; s_clear = 0;
    far_pos();
    rst = 1'b1;
    cyc(); cyc();
    check("reset.state", 32'(jif0.judge_state), 32'd0);
    check("reset.over",  32'(jif0.over), 32'd0);
    rst = 1'b0;

    // 1: grace period of 16 ticks, then armed
    s_enable = 1'b1;
    cyc();
    check("t1.grace", 32'(jif0.judge_state), 32'd1);
    ticks(15);
    check("t1.still_grace", 32'(jif0.judge_state), 32'd1);
    s_tick = 1'b1; cyc(); s_tick = 1'b0;
    check("t1.armed", 32'(jif0.judge_state), 32'd2);
    cyc();

    // 2: barrel overlap held two ticks -> lost
    set_pos(100, 200, 134, 218, 1'b1, 900, 450);
    ticks(1);
    check("t2.bovl", 32'(jif0.barrel_ovl), 32'd1);
    check("t2.over_early", 32'(jif0.over), 32'd0);
    s_tick = 1'b1; cyc(); s_tick = 1'b0;
    check("t2.over", 32'(jif0.over), 32'd1);
    check("t2.state", 32'(jif0.judge_state), 32'd3);
    cyc();

    // 3: shrunk-box boundaries
    arm();
    set_pos(100, 200, 146, 218, 1'b1, 900, 450);
    ticks(2);
    check("t3.edge_in", 32'(jif0.over), 32'd1);
    arm();
    set_pos(100, 200, 150, 218, 1'b1, 900, 450);
    ticks(10);
    check("t3.edge_out", 32'(jif0.over), 32'd0);
    check("t3.edge_bovl", 32'(jif0.barrel_ovl), 32'd0);

    // 4: broken run of overlaps, then invalid barrel
    arm();
    set_pos(100, 200, 134, 218, 1'b1, 900, 450); ticks(1);
    set_pos(100, 200, 600, 218, 1'b1, 900, 450); ticks(1);
    set_pos(100, 200, 134, 218, 1'b1, 900, 450); ticks(1);
    check("t4.broken", 32'(jif0.over), 32'd0);
    arm();
    set_pos(100, 200, 134, 218, 1'b0, 900, 450);
    ticks(5);
    check("t4.invalid", 32'(jif0.over), 32'd0);

    // 5: queue reached -> success; disable keeps it, clear drops it
    arm();
    set_pos(300, 40, 600, 400, 1'b0, 320, 60);
    ticks(3);
    check("t5.success", 32'(jif0.success), 32'd1);
    s_enable = 1'b0; cyc(); cyc();
    check("t5.sticky", 32'(jif0.success), 32'd1);
    s_enable = 1'b1;
    s_clear = 1'b1; cyc(); s_clear = 1'b0;
    check("t5.cleared", 32'(jif0.success), 32'd0);
    check("t5.idle", 32'(jif0.judge_state), 32'd0);
    cyc();
    check("t5.regrace", 32'(jif0.judge_state), 32'd1);

    // 6: simultaneous confirm on the WIN_TICKS=2 instance, then overlaps during grace
    arm();
    set_pos(100, 200, 134, 218, 1'b1, 120, 220);
    ticks(2);
    check("t6.both_over", 32'(jif1.over), 32'd1);
    check("t6.both_succ", 32'(jif1.success), 32'd0);
    far_pos();
    s_clear = 1'b1; cyc(); s_clear = 1'b0; cyc();
    set_pos(100, 200, 134, 218, 1'b1, 120, 220);
    ticks(10);
    check("t6.grace_over", 32'(jif0.over), 32'd0);
    check("t6.grace_state", 32'(jif1.judge_state), 32'd1);

    // Random play around the sprites
    for (int i = 0; i < 4000; i++) begin
      int mx, my;
      rst      = ($urandom_range(0, 399) == 0);
      s_clear  = ($urandom_range(0, 99) == 0);
      s_enable = ($urandom_range(0, 49) != 0);
      s_tick   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        mx = int'($urandom_range(100, 200));
        my = int'($urandom_range(100, 200));
        set_pos(mx, my,
                mx + int'($urandom_range(0, 70)) - 15,
                my + int'($urandom_range(0, 80)) - 20,
                ($urandom_range(0, 7) != 0),
                mx + int'($urandom_range(0, 70)) - 25,
                my + int'($urandom_range(0, 80)) - 30);
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
